// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter: line/word types, arbiter
// FSM state encoding (state value doubles as the arb_owner code).
package lc3b_types;

    localparam int LC3B_ADDR_W = 16;
    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        arb_idle    = 2'b00,
        arb_serve_i = 2'b01,
        arb_serve_d = 2'b10
    } lc3b_arb_state;

    // Owner code shown on the status port; unknown encodings report idle
    function automatic logic [1:0] arb_owner_code(input lc3b_arb_state state);
        logic [1:0] code;
        case (state)
            arb_serve_i: code = 2'b01;
            arb_serve_d: code = 2'b10;
            default:     code = 2'b00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select between I-cache and D-cache requests.
// With RR_EN set, contention goes to the side not granted last.
module mem_arbiter_pick #(
    parameter bit RR_EN = 1'b0
) (
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last_grant_d,
    output logic o_grant_i,
    output logic o_grant_d
);

    logic w_prefer_i;

    // D wins contention unless the round-robin pointer says it went last
    always_comb begin
        w_prefer_i = RR_EN & i_last_grant_d;
        o_grant_d  = i_req_d & ~(i_req_i & w_prefer_i);
        o_grant_i  = i_req_i & ~o_grant_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding physical memory arbiter for the LC-3b I/D caches.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on contention).
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = LC3B_ADDR_W,
    parameter int LINE_W = LC3B_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        arb_owner
);

    lc3b_arb_state     r_state;
    lc3b_arb_state     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_op_write;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_last_grant_d;
    logic              w_busy;

    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    logic r_last_grant_d;

    // Remember which side won the most recent grant (reset points at I)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant_d <= 1'b0;
        end else if (r_state == arb_idle && w_grant_d) begin
            r_last_grant_d <= 1'b1;
        end else if (r_state == arb_idle && w_grant_i) begin
            r_last_grant_d <= 1'b0;
        end else begin
            r_last_grant_d <= r_last_grant_d;
        end
    end

    assign w_last_grant_d = r_last_grant_d;
`else
    localparam bit RR_EN = 1'b0;
    assign w_last_grant_d = 1'b0;
`endif

    mem_arbiter_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .i_req_i        (w_req_i),
        .i_req_d        (w_req_d),
        .i_last_grant_d (w_last_grant_d),
        .o_grant_i      (w_grant_i),
        .o_grant_d      (w_grant_d)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= arb_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: grant from IDLE, return to IDLE on memory completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            arb_idle: begin
                if (w_grant_d) begin
                    w_next_state = arb_serve_d;
                end else if (w_grant_i) begin
                    w_next_state = arb_serve_i;
                end else begin
                    w_next_state = arb_idle;
                end
            end
            arb_serve_i, arb_serve_d: begin
                if (pmem_resp) begin
                    w_next_state = arb_idle;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = arb_idle;
        endcase
    end

    // Capture the winner's request at the grant edge; held for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= {ADDR_W{1'b0}};
            r_wdata    <= {LINE_W{1'b0}};
            r_op_write <= 1'b0;
        end else if (r_state == arb_idle && w_grant_d) begin
            r_addr     <= d_address;
            r_wdata    <= d_wdata;
            r_op_write <= d_write;
        end else if (r_state == arb_idle && w_grant_i) begin
            r_addr     <= i_address;
            r_wdata    <= {LINE_W{1'b0}};
            r_op_write <= 1'b0;
        end else begin
            r_addr     <= r_addr;
            r_wdata    <= r_wdata;
            r_op_write <= r_op_write;
        end
    end

    // Strobes derive from state so an async reset drops them immediately
    assign w_busy       = (r_state == arb_serve_i) || (r_state == arb_serve_d);
    assign pmem_read    = w_busy & ~r_op_write;
    assign pmem_write   = w_busy & r_op_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    assign i_resp    = (r_state == arb_serve_i) & pmem_resp;
    assign d_resp    = (r_state == arb_serve_d) & pmem_resp;
    assign i_rdata   = pmem_rdata;
    assign d_rdata   = pmem_rdata;
    assign arb_owner = arb_owner_code(r_state);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever a resp pulse appears.
module tb_mem_arbiter;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   arb_owner;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .arb_owner    (arb_owner)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory side of one transaction: wait for strobe, hold lat cycles, then complete
    task automatic mem_txn(input bit is_d, input bit wr, input logic [15:0] addr,
                           input logic [127:0] data, input int lat, output int waited);
        waited = 0;
        while (!(pmem_read || pmem_write) && waited < 20) begin
            tick();
            waited++;
        end
        chk("strobe_seen", 1'(waited < 20), 1'b1);
        if (waited < 20) begin
            for (int k = 0; k < lat; k++) begin
                chk("strobe_hold", {pmem_read, pmem_write}, wr ? 2'b01 : 2'b10);
                chk("addr_hold", pmem_address, addr);
                tick();
            end
            pmem_rdata = data;
            pmem_resp  = 1'b1;
            if (is_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
            tick();
            pmem_resp = 1'b0;
        end
    endtask

    // Monitor: every resp pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (i_resp || d_resp)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {i_resp, d_resp}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_side", {i_resp, d_resp}, mon_e.is_d ? 2'b01 : 2'b10);
                chk("resp_addr", pmem_address, mon_e.addr);
                chk("resp_op", {pmem_read, pmem_write}, mon_e.wr ? 2'b01 : 2'b10);
                chk("resp_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.rdata);
                if (mon_e.wr) chk("resp_wdata", pmem_wdata, mon_e.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           waited;
        bit           srv_d;
        logic [15:0]  w16;
        logic [127:0] line;

        rst_n = 1'b0; i_read = 1'b0; i_address = 16'h0000;
        d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = 128'h0;
        pmem_rdata = 128'h0; pmem_resp = 1'b0;
        #1;
        chk("reset_owner", arb_owner, 2'b00);
        chk("reset_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("reset_addr", pmem_address, 16'h0000);
        chk("reset_wdata", pmem_wdata, 128'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // I-cache only read, 5-cycle memory
        i_read = 1'b1; i_address = 16'h1230;
        #1 chk("i_arb_cycle", pmem_read, 1'b0);
        exp_q.push_back('{1'b0, 1'b0, 16'h1230, 128'h0, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5});
        tick();
        chk("i_grant_owner", arb_owner, 2'b01);
        chk("i_grant_read", pmem_read, 1'b1);
        chk("i_grant_addr", pmem_address, 16'h1230);
        mem_txn(1'b0, 1'b0, 16'h1230, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 5, waited);
        chk("i_resp_pulse_end", {i_resp, d_resp}, 2'b00);

        // Contention: D write beats I read, then I follows after one IDLE cycle
        i_read = 1'b1; i_address = 16'h1240;
        d_write = 1'b1; d_address = 16'h2000; d_wdata = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;
        exp_q.push_back('{1'b1, 1'b1, 16'h2000, 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F, 128'h0});
        exp_q.push_back('{1'b0, 1'b0, 16'h1240, 128'h0, 128'h11112222_33334444_55556666_77778888});
        tick();
        chk("cont_d_first", {arb_owner, pmem_write}, 3'b101);
        mem_txn(1'b1, 1'b1, 16'h2000, 128'h0, 3, waited);
        chk("cont_idle_owner", arb_owner, 2'b00);
        chk("cont_idle_strobe", pmem_read, 1'b0);
        mem_txn(1'b0, 1'b0, 16'h1240, 128'h11112222_33334444_55556666_77778888, 2, waited);
        chk("cont_i_gap", waited, 1);

        // Four back-to-back contended rounds
        i_read = 1'b1; i_address = 16'h1300;
        d_read = 1'b1; d_address = 16'h3000;
        for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            srv_d = (r % 2 == 0);
`else
            srv_d = 1'b1;
`endif
            w16  = 16'hC000 | r[15:0];
            line = {8{w16}};
            exp_q.push_back('{srv_d, 1'b0, srv_d ? d_address : i_address, 128'h0, line});
            mem_txn(srv_d, 1'b0, srv_d ? d_address : i_address, line, 2, waited);
            chk("b2b_gap", waited, 1);
            chk("b2b_idle_owner", arb_owner, 2'b00);
            if (srv_d) begin
                d_read = 1'b1; d_address = d_address + 16'h0010;
            end else begin
                i_read = 1'b1; i_address = i_address + 16'h0010;
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();

        // D read whose request drops mid-service
        d_read = 1'b1; d_address = 16'h4000;
        exp_q.push_back('{1'b1, 1'b0, 16'h4000, 128'h0, 128'hDEADBEEF_00000000_CAFEF00D_12345678});
        tick();
        chk("abn_grant", {arb_owner, pmem_read}, 3'b101);
        tick();
        d_read = 1'b0; d_address = 16'h5555;
        #1;
        chk("abn_hold_read", pmem_read, 1'b1);
        chk("abn_hold_addr", pmem_address, 16'h4000);
        mem_txn(1'b1, 1'b0, 16'h4000, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 3, waited);
        chk("abn_pulse_one", d_resp, 1'b0);

        // Stray completion in IDLE
        pmem_resp = 1'b1;
        #1;
        chk("stray_resp", {i_resp, d_resp}, 2'b00);
        tick();
        chk("stray_owner", arb_owner, 2'b00);
        pmem_resp = 1'b0;

        // Illegal read+write request is issued as a write
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h6000; d_wdata = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        exp_q.push_back('{1'b1, 1'b1, 16'h6000, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h0});
        tick();
        chk("rw_is_write", {pmem_read, pmem_write}, 2'b01);
        mem_txn(1'b1, 1'b1, 16'h6000, 128'h0, 1, waited);

        // Asynchronous reset in the middle of a D write
        d_write = 1'b1; d_address = 16'h7000; d_wdata = 128'h5A;
        tick();
        chk("rst_pre_write", {arb_owner, pmem_write}, 3'b101);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst_async_owner", arb_owner, 2'b00);
        chk("rst_async_resp", {i_resp, d_resp}, 2'b00);
        chk("rst_async_addr", pmem_address, 16'h0000);
        d_write = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("rst_post_idle", {arb_owner, pmem_read, pmem_write}, 4'b0000);

        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
